// File: rtl/mover_pkg.sv
// Shared encodings for the N-lane BRAM multiply mover: job modes, FSM states, pipeline tag.
// Pure declarations; no timing or flow control of its own.
package mover_pkg;

  localparam logic [1:0] MODE_MUL_U = 2'b00;
  localparam logic [1:0] MODE_MUL_S = 2'b01;
  localparam logic [1:0] MODE_MAC_U = 2'b10;
  localparam logic [1:0] MODE_PASS  = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Travels alongside the BRAM0 read data; 'last' marks the final word of a job.
  typedef struct packed {
    logic vld;
    logic last;
  } pipe_tag_t;

endpackage

// File: rtl/mul_lane.sv
// One multiplier lane: registered W x W product (signed/unsigned) plus a running accumulator.
// Latency 1 cycle from i_vld to o_vld; no backpressure, accepts a pair every cycle.
module mul_lane #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_vld,
  input  logic           i_signed,
  input  logic           i_acc_clr,
  input  logic           i_acc_en,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_vld,
  output logic [2*W-1:0] o_prod,
  output logic [2*W-1:0] o_acc
);

  logic [2*W-1:0] w_a_ext;
  logic [2*W-1:0] w_b_ext;
  logic [2*W-1:0] w_prod;
  logic           r_vld;
  logic [2*W-1:0] r_prod;
  logic [2*W-1:0] r_acc;

  // The low 2W bits of the sign-extended product are the exact signed product.
  assign w_a_ext = {{W{i_signed & i_a[W-1]}}, i_a};
  assign w_b_ext = {{W{i_signed & i_b[W-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_prod <= '0;
      r_acc  <= '0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) r_prod <= w_prod;
      // Accumulator adds the raw product at the same edge so the sum is ready with the last product.
      if (i_acc_clr) r_acc <= '0;
      else if (i_acc_en && i_vld) r_acc <= r_acc + w_prod;
    end
  end

  assign o_vld  = r_vld;
  assign o_prod = r_prod;
  assign o_acc  = r_acc;

endmodule

// File: rtl/mul_mover_nlane.sv
// Streams words from BRAM0, splits them into NUM_LANES operand pairs, multiplies/accumulates/passes into BRAM1.
// Read-to-write latency 2 cycles (job period N+4); no backpressure, BRAMs are always ready.
module mul_mover_nlane
  import mover_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int IN_DATA_WIDTH = 8,
  parameter int AWIDTH        = 12,
  parameter int CNT           = 31,
  parameter int DWIDTH        = 2*NUM_LANES*IN_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run,
  input  logic [1:0]        i_mode,
  input  logic [CNT-1:0]    i_num_cnt,
  input  logic [AWIDTH-1:0] i_src_base,
  input  logic [AWIDTH-1:0] i_dst_base,
  output logic              o_idle,
  output logic              o_read,
  output logic              o_write,
  output logic              o_done,
  output logic [AWIDTH-1:0] addr_b0,
  output logic              ce_b0,
  output logic              we_b0,
  output logic [DWIDTH-1:0] d0_b0,
  input  logic [DWIDTH-1:0] q0_b0,
  output logic [AWIDTH-1:0] addr_b1,
  output logic              ce_b1,
  output logic              we_b1,
  output logic [DWIDTH-1:0] d0_b1,
  input  logic [DWIDTH-1:0] q0_b1
);

  localparam int W = IN_DATA_WIDTH;
  localparam logic [AWIDTH-1:0] A_ONE = AWIDTH'(1);
  localparam logic [CNT-1:0]    C_ONE = CNT'(1);

  logic [1:0]        r_state;
  logic [1:0]        r_mode;
  logic [CNT-1:0]    r_num;
  logic [CNT-1:0]    r_rd_cnt;
  logic [AWIDTH-1:0] r_rd_addr;
  logic [AWIDTH-1:0] r_wr_addr;
  logic              r_drain;
  pipe_tag_t         r_s1;
  logic              r_s2_last;
  logic [DWIDTH-1:0] r_pass_dat;

  logic                 w_run;
  logic                 w_rd_last;
  logic                 w_wr_vld;
  logic                 w_wr_stb;
  logic [NUM_LANES-1:0] w_lane_vld;
  logic [DWIDTH-1:0]    w_prod_cat;
  logic [DWIDTH-1:0]    w_acc_cat;
  logic [DWIDTH-1:0]    w_wr_dat;
  logic                 w_unused_q1;

  assign w_run       = (r_state == S_RUN);
  assign w_rd_last   = (r_rd_cnt == r_num - C_ONE);
  assign w_wr_vld    = &w_lane_vld;
  // MAC emits only the final sums, so it waits for the word tagged last.
  assign w_wr_stb    = w_wr_vld && ((r_mode != MODE_MAC_U) || r_s2_last);
  assign w_unused_q1 = ^q0_b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mode     <= MODE_MUL_U;
      r_num      <= '0;
      r_rd_cnt   <= '0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_drain    <= 1'b0;
      r_s1       <= '0;
      r_s2_last  <= 1'b0;
      r_pass_dat <= '0;
    end else begin
      r_s1.vld   <= w_run;
      r_s1.last  <= w_run && w_rd_last;
      r_s2_last  <= r_s1.last;
      r_pass_dat <= q0_b0;
      if (w_wr_stb) r_wr_addr <= r_wr_addr + A_ONE;

      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_mode    <= i_mode;
            r_num     <= i_num_cnt;
            r_rd_addr <= i_src_base;
            r_wr_addr <= i_dst_base;
            r_rd_cnt  <= '0;
            r_state   <= (i_num_cnt == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          r_rd_addr <= r_rd_addr + A_ONE;
          r_rd_cnt  <= r_rd_cnt + C_ONE;
          if (w_rd_last) begin
            r_drain <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Two drain cycles: one for the BRAM read, one for the lane register.
          r_drain <= 1'b1;
          if (r_drain) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  genvar k;
  for (k = 0; k < NUM_LANES; k++) begin : g_lane
    mul_lane #(.W(W)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_vld     (r_s1.vld),
      .i_signed  (r_mode == MODE_MUL_S),
      .i_acc_clr (r_state == S_IDLE && i_run),
      .i_acc_en  (r_mode == MODE_MAC_U),
      .i_a       (q0_b0[2*k*W +: W]),
      .i_b       (q0_b0[(2*k+1)*W +: W]),
      .o_vld     (w_lane_vld[k]),
      .o_prod    (w_prod_cat[2*k*W +: 2*W]),
      .o_acc     (w_acc_cat[2*k*W +: 2*W])
    );
  end

  always_comb begin
    w_wr_dat = '0;
    if (w_wr_stb) begin
      case (r_mode)
        MODE_PASS:  w_wr_dat = r_pass_dat;
        MODE_MAC_U: w_wr_dat = w_acc_cat;
        default:    w_wr_dat = w_prod_cat;
      endcase
    end
  end

  assign o_idle  = (r_state == S_IDLE);
  assign o_read  = w_run;
  assign o_write = r_s1.vld || w_wr_vld;
  assign o_done  = (r_state == S_DONE);

  assign ce_b0   = w_run;
  assign addr_b0 = w_run ? r_rd_addr : '0;
  assign we_b0   = 1'b0;
  assign d0_b0   = '0;

  assign ce_b1   = w_wr_stb;
  assign we_b1   = w_wr_stb;
  assign addr_b1 = w_wr_stb ? r_wr_addr : '0;
  assign d0_b1   = w_wr_dat;

endmodule

// File: tb/tb_mul_mover_nlane.sv
// Bench for mul_mover_nlane: BRAM models, write/read monitors and a word-level reference model.
module tb_mul_mover_nlane;
  import mover_pkg::*;

  localparam int L  = 4;
  localparam int W  = 8;
  localparam int AW = 12;
  localparam int CW = 31;
  localparam int DW = 2*L*W;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_run;
  logic [1:0]    i_mode;
  logic [CW-1:0] i_num_cnt;
  logic [AW-1:0] i_src_base;
  logic [AW-1:0] i_dst_base;
  logic          o_idle, o_read, o_write, o_done;
  logic [AW-1:0] addr_b0, addr_b1;
  logic          ce_b0, we_b0, ce_b1, we_b1;
  logic [DW-1:0] d0_b0, d0_b1;
  logic [DW-1:0] q0_b0 = '0;
  logic [DW-1:0] q0_b1 = '0;

  always #5 clk = ~clk;

  mul_mover_nlane #(.NUM_LANES(L), .IN_DATA_WIDTH(W), .AWIDTH(AW), .CNT(CW)) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_mode(i_mode), .i_num_cnt(i_num_cnt),
    .i_src_base(i_src_base), .i_dst_base(i_dst_base),
    .o_idle(o_idle), .o_read(o_read), .o_write(o_write), .o_done(o_done),
    .addr_b0(addr_b0), .ce_b0(ce_b0), .we_b0(we_b0), .d0_b0(d0_b0), .q0_b0(q0_b0),
    .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1), .d0_b1(d0_b1), .q0_b1(q0_b1)
  );

  logic [DW-1:0] mem0 [0:4095];
  logic [DW-1:0] mem1 [0:4095];

  typedef struct {
    int            addr;
    logic [DW-1:0] dat;
    int            cyc;
  } wr_t;

  wr_t wr_q[$];
  int  rd_q[$];
  int  done_q[$];
  int  cyc = 0;
  int  bad_side = 0;
  int  errors = 0;
  int  checks = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ce_b0) q0_b0 <= mem0[addr_b0];
  end

  always @(negedge clk) begin
    if (ce_b0) rd_q.push_back(int'(addr_b0));
    if (ce_b1) begin
      wr_q.push_back('{int'(addr_b1), d0_b1, cyc});
      mem1[addr_b1] = d0_b1;
      if (!we_b1 || !o_write) bad_side++;
    end
    if (we_b0 || d0_b0 != '0) bad_side++;
    if (o_done) done_q.push_back(cyc);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int op_val(input logic [DW-1:0] w, input int idx, input bit sgn);
    int v;
    v = int'(w[idx*W +: W]);
    if (sgn && v >= 2**(W-1)) v = v - 2**W;
    return v;
  endfunction

  function automatic logic [DW-1:0] mul_word(input bit sgn, input logic [DW-1:0] w);
    logic [DW-1:0] r;
    logic [31:0]   p;
    r = '0;
    for (int k = 0; k < L; k++) begin
      p = op_val(w, 2*k, sgn) * op_val(w, 2*k+1, sgn);
      r[2*k*W +: 2*W] = p[2*W-1:0];
    end
    return r;
  endfunction

  task automatic run_job(input logic [1:0] mode, input int n, input int src, input int dst,
                         input int inject_at, output int start);
    wr_t           exp_q[$];
    logic [31:0]   sum [L];
    logic [DW-1:0] w, r;
    int            done_at;
    rd_q.delete(); wr_q.delete(); done_q.delete();
    i_mode = mode; i_num_cnt = CW'(n); i_src_base = AW'(src); i_dst_base = AW'(dst);
    i_run = 1'b1;
    start = cyc;
    tick();
    i_run = 1'b0;
    i_mode = 2'($urandom); i_num_cnt = CW'($urandom_range(0, 50));
    i_src_base = AW'($urandom); i_dst_base = AW'($urandom);
    for (int k = 0; k < n + 12 && done_q.size() == 0; k++) begin
      i_run = (k == inject_at);
      tick();
    end
    i_run = 1'b0;

    if (mode == MODE_MAC_U) begin
      for (int k = 0; k < L; k++) sum[k] = 0;
      for (int i = 0; i < n; i++) begin
        w = mem0[(src + i) % 4096];
        for (int k = 0; k < L; k++) sum[k] = sum[k] + 32'(op_val(w, 2*k, 0) * op_val(w, 2*k+1, 0));
      end
      r = '0;
      for (int k = 0; k < L; k++) r[2*k*W +: 2*W] = sum[k][2*W-1:0];
      if (n > 0) exp_q.push_back('{dst % 4096, r, start + n + 2});
    end else begin
      for (int i = 0; i < n; i++) begin
        w = mem0[(src + i) % 4096];
        r = (mode == MODE_PASS) ? w : mul_word(mode == MODE_MUL_S, w);
        exp_q.push_back('{(dst + i) % 4096, r, start + 3 + i});
      end
    end

    done_at = (done_q.size() > 0) ? done_q[0] : -1;
    check("done_cycle", 64'(done_at), 64'(start + ((n == 0) ? 1 : n + 3)));
    check("wr_count", 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      check("wr_addr", 64'(wr_q[i].addr), 64'(exp_q[i].addr));
      check("wr_data", wr_q[i].dat, exp_q[i].dat);
      check("wr_cycle", 64'(wr_q[i].cyc), 64'(exp_q[i].cyc));
    end
    check("rd_count", 64'(rd_q.size()), 64'(n));
    for (int i = 0; i < rd_q.size() && i < n; i++)
      check("rd_addr", 64'(rd_q[i]), 64'((src + i) % 4096));
    tick();
    check("idle_after_done", {62'd0, o_idle, o_done}, 64'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, s2, s;
    int n, src, dst;
    logic [1:0] m;

    reset = 1'b1; i_run = 1'b0; i_mode = '0; i_num_cnt = '0; i_src_base = '0; i_dst_base = '0;
    for (int i = 0; i < 4096; i++) mem0[i] = {$urandom, $urandom};
    tick(); tick(); tick();
    check("rst_status", {57'd0, o_idle, o_read, o_write, o_done, ce_b0, ce_b1, we_b1}, 64'h40);
    check("rst_addr", {40'd0, addr_b0, addr_b1}, 64'd0);
    check("rst_d0_b1", d0_b1, 64'd0);
    reset = 1'b0;
    tick();
    check("idle_status", {57'd0, o_idle, o_read, o_write, o_done, ce_b0, ce_b1, we_b1}, 64'h40);

    // MUL unsigned, word 0 holds a=3, b=5 in every lane
    mem0[0] = 64'h0503050305030503;
    run_job(MODE_MUL_U, 3, 0, 12'h010, -1, s1);
    check("mul_u_3x5", mem1[12'h010], 64'h000F000F000F000F);

    // Signed vs unsigned on lane0 a=0xFF, b=0x02; started back-to-back after the previous DONE
    mem0[12'h040] = 64'h7F80030305050_2FF;
    run_job(MODE_MUL_S, 1, 12'h040, 12'h300, -1, s2);
    check("back_to_back_period", 64'(s2 - s1), 64'(3 + 4));
    check("mul_s_slot0", {48'd0, mem1[12'h300][15:0]}, 64'hFFFE);
    run_job(MODE_MUL_U, 1, 12'h040, 12'h301, -1, s);
    check("mul_u_slot0", {48'd0, mem1[12'h301][15:0]}, 64'h01FE);

    // MAC over four words of 0x10 * 0x10
    for (int i = 0; i < 4; i++) mem0[12'h050 + i] = 64'h1010101010101010;
    run_job(MODE_MAC_U, 4, 12'h050, 12'h400, -1, s);
    check("mac_sum", mem1[12'h400], 64'h0400040004000400);

    // PASS with wrapping source addresses
    run_job(MODE_PASS, 4, 12'hFFE, 12'h500, -1, s);

    // Zero-length job
    run_job(MODE_MUL_U, 0, 12'h030, 12'h600, -1, s);

    // Extra i_run pulse while running must be ignored
    run_job(MODE_MUL_U, 5, 12'h020, 12'h700, 1, s);

    for (int j = 0; j < 6; j++) begin
      m   = 2'($urandom_range(0, 3));
      n   = $urandom_range(1, 8);
      src = $urandom_range(0, 4095);
      dst = $urandom_range(0, 4095);
      run_job(m, n, src, dst, -1, s);
    end

    // Reset in the middle of a 10-word MUL job after 4 reads
    rd_q.delete(); wr_q.delete(); done_q.delete();
    i_mode = MODE_MUL_U; i_num_cnt = CW'(10); i_src_base = 12'h100; i_dst_base = 12'h200;
    i_run = 1'b1;
    tick();
    i_run = 1'b0;
    tick(); tick(); tick();
    check("mid_rd_count", 64'(rd_q.size()), 64'd4);
    reset = 1'b1;
    tick();
    check("mid_rst_status", {57'd0, o_idle, o_read, o_write, o_done, ce_b0, ce_b1, we_b1}, 64'h40);
    check("mid_rst_addr", {40'd0, addr_b0, addr_b1}, 64'd0);
    check("mid_rst_d0_b1", d0_b1, 64'd0);
    check("mid_wr_before", 64'(wr_q.size()), 64'd2);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("mid_wr_after", 64'(wr_q.size()), 64'd2);
    check("mid_rd_after", 64'(rd_q.size()), 64'd4);
    check("mid_no_done", 64'(done_q.size()), 64'd0);
    check("mid_idle", {63'd0, o_idle}, 64'd1);

    check("side_channels", 64'(bad_side), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
